light_driver: RTL

- Receiving end of the master_fsm mode/shift interface.
- Consumes the one-hot mode state and the f1/f2 shift pulses, holds the BLINK1 and BLINK2 rate settings, and drives the bike light output.
- Contains a tick prescaler, per-mode rate registers, a blink phase counter and a double-flash pattern sequencer.

---
 rtl/light_driver.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/light_driver.sv
// -----------------------------------------------------------------------------
// light_driver
//
// Receiving end of the master_fsm mode/shift interface. Holds the BLINK1 and
// BLINK2 rate settings, divides the clock into base ticks and drives the bike
// lamp as steady off, steady on, a square wave (BLINK1) or a double-flash
// pattern (BLINK2).
//
// Parameters:
//   TICK_DIV        clock cycles per base tick (2..65535)
//
// Ports:
//   clk             system clock, rising edge
//   reset           asynchronous, active-high reset
//   state[3:0]      one-hot mode: 0001 OFF, 0010 ON, 0100 BLINK1, 1000 BLINK2
//   f1_shift_left   1-cycle pulse, BLINK1 faster (honoured only in BLINK1)
//   f1_shift_right  1-cycle pulse, BLINK1 slower (honoured only in BLINK1)
//   f2_shift_left   1-cycle pulse, BLINK2 faster (honoured only in BLINK2)
//   f2_shift_right  1-cycle pulse, BLINK2 slower (honoured only in BLINK2)
//   light           registered lamp drive
//   f1_rate[1:0]    current BLINK1 rate index (half period = 2^(3-r) ticks)
//   f2_rate[1:0]    current BLINK2 rate index (slot length = 2^(3-r) ticks)
// -----------------------------------------------------------------------------
module light_driver #(
  parameter int TICK_DIV = 1000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] state,
  input  logic       f1_shift_left,
  input  logic       f1_shift_right,
  input  logic       f2_shift_left,
  input  logic       f2_shift_right,
  output logic       light,
  output logic [1:0] f1_rate,
  output logic [1:0] f2_rate
);

  localparam int TICK_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);

  localparam logic [3:0] ST_OFF    = 4'b0001;
  localparam logic [3:0] ST_ON     = 4'b0010;
  localparam logic [3:0] ST_BLINK1 = 4'b0100;
  localparam logic [3:0] ST_BLINK2 = 4'b1000;

  // Double flash: bit n is the lamp level during slot n (slots 0 and 2 lit).
  localparam logic [7:0] SLOT_PATTERN = 8'b0000_0101;

  logic [TICK_W-1:0] tick_cnt, tick_cnt_nxt;
  logic [2:0]        ph_cnt, ph_cnt_nxt;
  logic [2:0]        slot, slot_nxt;
  logic              blink_q, blink_nxt;
  logic [3:0]        prev_state;
  logic              light_nxt;
  logic [1:0]        f1_rate_nxt, f2_rate_nxt;
  logic              mode_change;
  logic              tick;

  // Last phase-counter value of a half period: H-1 with H = 2^(3-r).
  function automatic logic [2:0] half_last(input logic [1:0] r);
    logic [2:0] res;
    case (r)
      2'd0:    res = 3'd7;
      2'd1:    res = 3'd3;
      2'd2:    res = 3'd1;
      default: res = 3'd0;
    endcase
    return res;
  endfunction

  // Saturating rate step; simultaneous left and right cancel out.
  function automatic logic [1:0] rate_step(input logic [1:0] r,
                                           input logic       faster,
                                           input logic       slower);
    logic [1:0] res;
    res = r;
    if (faster && !slower && (r != 2'd3)) res = r + 2'd1;
    else if (slower && !faster && (r != 2'd0)) res = r - 2'd1;
    return res;
  endfunction

  assign mode_change = (state != prev_state);
  assign tick        = (tick_cnt == TICK_LAST);

  always_comb begin
    tick_cnt_nxt = tick_cnt;
    ph_cnt_nxt   = ph_cnt;
    slot_nxt     = slot;
    blink_nxt    = blink_q;
    light_nxt    = 1'b0;

    if (mode_change) begin
      // Fresh entry: prescaler clears too, so the first phase is exactly H ticks.
      tick_cnt_nxt = '0;
      ph_cnt_nxt   = 3'd0;
      slot_nxt     = 3'd0;
      blink_nxt    = 1'b1;
    end else begin
      tick_cnt_nxt = tick ? '0 : tick_cnt + TICK_W'(1);
      if (tick) begin
        // >= rather than == so a rate raised mid-phase ends the phase at the
        // next tick instead of counting past the new limit.
        if (state == ST_BLINK1) begin
          if (ph_cnt >= half_last(f1_rate)) begin
            ph_cnt_nxt = 3'd0;
            blink_nxt  = ~blink_q;
          end else begin
            ph_cnt_nxt = ph_cnt + 3'd1;
          end
        end else if (state == ST_BLINK2) begin
          if (ph_cnt >= half_last(f2_rate)) begin
            ph_cnt_nxt = 3'd0;
            slot_nxt   = slot + 3'd1;
          end else begin
            ph_cnt_nxt = ph_cnt + 3'd1;
          end
        end
      end
    end

    // Lamp follows the post-edge phase so entry shows the lit phase at once.
    case (state)
      ST_OFF:    light_nxt = 1'b0;
      ST_ON:     light_nxt = 1'b1;
      ST_BLINK1: light_nxt = blink_nxt;
      ST_BLINK2: light_nxt = SLOT_PATTERN[slot_nxt];
      default:   light_nxt = 1'b0;
    endcase

    f1_rate_nxt = (state == ST_BLINK1) ?
                  rate_step(f1_rate, f1_shift_left, f1_shift_right) : f1_rate;
    f2_rate_nxt = (state == ST_BLINK2) ?
                  rate_step(f2_rate, f2_shift_left, f2_shift_right) : f2_rate;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tick_cnt   <= '0;
      ph_cnt     <= 3'd0;
      slot       <= 3'd0;
      blink_q    <= 1'b0;
      prev_state <= ST_OFF;
      light      <= 1'b0;
      f1_rate    <= 2'd1;
      f2_rate    <= 2'd1;
    end else begin
      tick_cnt   <= tick_cnt_nxt;
      ph_cnt     <= ph_cnt_nxt;
      slot       <= slot_nxt;
      blink_q    <= blink_nxt;
      prev_state <= state;
      light      <= light_nxt;
      f1_rate    <= f1_rate_nxt;
      f2_rate    <= f2_rate_nxt;
    end
  end

endmodule
